// File: rtl/truth_table_sweeper_if.sv
// ============================================================================
// truth_table_sweeper_if : control, status and stimulus/response bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [2:0] resp_in;
  logic [3:0] vec_out;
  logic       busy;
  logic       done;
  logic       pass;
  logic [4:0] mismatch_count;
  logic       first_fail_vld;
  logic [3:0] first_fail_vec;

  // Controller / logic-under-test side
  modport master (
    output start, abort, resp_in,
    input  vec_out, busy, done, pass, mismatch_count, first_fail_vld, first_fail_vec
  );

  // Sweeper side
  modport slave (
    input  start, abort, resp_in,
    output vec_out, busy, done, pass, mismatch_count, first_fail_vld, first_fail_vec
  );
endinterface

`default_nettype wire

// File: rtl/truth_table_sweeper.sv
// ============================================================================
// truth_table_sweeper : walks a 4-input vector through 0..15 and checks that
// the three implementation outputs agree (and optionally match a golden table)
// Rev 1.0
// ============================================================================
`default_nettype none

module truth_table_sweeper #(
  parameter int          DWELL_CYCLES = 4,
  parameter bit          CHECK_GOLDEN = 1'b1,
  parameter logic [15:0] EXPECT_TT    = 16'h0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  truth_table_sweeper_if.slave   bus
);

  localparam int            DW         = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    vec_q, vec_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [4:0]    count_q, count_d;
  logic          ffv_q, ffv_d;
  logic [3:0]    ffvec_q, ffvec_d;

  logic w_begin;
  logic w_sample;
  logic w_disagree;
  logic w_golden_bad;
  logic w_fail;

  assign w_disagree   = (|bus.resp_in) && !(&bus.resp_in);
  assign w_golden_bad = CHECK_GOLDEN && (bus.resp_in[0] != EXPECT_TT[vec_q]);
  // abort discards whatever sample would have been taken this cycle
  assign w_sample     = (state_q == APPLY) && (dwell_q == DWELL_LAST) && !bus.abort;
  assign w_fail       = w_sample && (w_disagree || w_golden_bad);
  assign w_begin      = bus.start && !bus.abort && (state_q != APPLY);

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    dwell_d = dwell_q;
    busy_d  = busy_q;
    done_d  = done_q;
    pass_d  = pass_q;
    count_d = count_q;
    ffv_d   = ffv_q;
    ffvec_d = ffvec_q;

    if (w_fail) begin
      if (count_q != 5'd16) begin
        count_d = count_q + 5'd1;
      end
      if (!ffv_q) begin
        ffv_d   = 1'b1;
        ffvec_d = vec_q;
      end
    end

    case (state_q)
      IDLE: begin
        if (w_begin) begin
          state_d = APPLY;
        end
      end
      APPLY: begin
        if (bus.abort) begin
          state_d = IDLE;
          vec_d   = 4'd0;
          dwell_d = '0;
          busy_d  = 1'b0;
          done_d  = 1'b0;
        end else if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (vec_q != 4'd15) begin
            vec_d = vec_q + 4'd1;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (count_d == 5'd0);
          end
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
          vec_d   = 4'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
        end else if (w_begin) begin
          state_d = APPLY;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A new sweep always starts from vector 0 with all results cleared
    if (w_begin) begin
      vec_d   = 4'd0;
      dwell_d = '0;
      busy_d  = 1'b1;
      done_d  = 1'b0;
      pass_d  = 1'b0;
      count_d = 5'd0;
      ffv_d   = 1'b0;
      ffvec_d = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= 4'd0;
      dwell_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      count_q <= 5'd0;
      ffv_q   <= 1'b0;
      ffvec_q <= 4'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      dwell_q <= dwell_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      count_q <= count_d;
      ffv_q   <= ffv_d;
      ffvec_q <= ffvec_d;
    end
  end

  assign bus.vec_out        = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.mismatch_count = count_q;
  assign bus.first_fail_vld = ffv_q;
  assign bus.first_fail_vec = ffvec_q;

endmodule

`default_nettype wire

// File: tb/tb_truth_table_sweeper.sv
// ============================================================================
// tb_truth_table_sweeper : directed bench for truth_table_sweeper
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_truth_table_sweeper;

  localparam logic [15:0] TT     = 16'h6A9C;
  localparam logic [15:0] TT_BAD = TT ^ 16'h0208;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [15:0] inv1;
  logic [15:0] invall;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  // Logic under test: all three outputs follow TT unless a fault mask is set
  function automatic logic [2:0] lut(input logic [3:0] v, input logic [15:0] i1,
                                     input logic [15:0] ia);
    logic [15:0] t;
    logic        b;
    t = TT;
    b = t[v] ^ ia[v];
    return {b, b ^ i1[v], b};
  endfunction

  truth_table_sweeper_if if0 ();
  truth_table_sweeper_if if1 ();
  truth_table_sweeper_if if2 ();
  truth_table_sweeper_if if3 ();

  assign if0.start = start;  assign if0.abort = abort;
  assign if1.start = start;  assign if1.abort = abort;
  assign if2.start = start;  assign if2.abort = abort;
  assign if3.start = start;  assign if3.abort = abort;
  assign if0.resp_in = lut(if0.vec_out, inv1, invall);
  assign if1.resp_in = lut(if1.vec_out, inv1, invall);
  assign if2.resp_in = lut(if2.vec_out, inv1, invall);
  assign if3.resp_in = lut(if3.vec_out, inv1, invall);

  truth_table_sweeper #(.DWELL_CYCLES(4), .CHECK_GOLDEN(1'b1), .EXPECT_TT(TT))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  truth_table_sweeper #(.DWELL_CYCLES(4), .CHECK_GOLDEN(1'b1), .EXPECT_TT(TT_BAD))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  truth_table_sweeper #(.DWELL_CYCLES(4), .CHECK_GOLDEN(1'b0), .EXPECT_TT(TT_BAD))
    u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  truth_table_sweeper #(.DWELL_CYCLES(1), .CHECK_GOLDEN(1'b1), .EXPECT_TT(TT))
    u_dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

  typedef struct {
    logic [15:0] inv1;
    logic [15:0] invall;
    int          restart_k;
    logic [4:0]  cnt;
    logic        ffv;
    logic [3:0]  ffvec;
    logic        pass;
  } row_t;

  row_t rows[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] status0();
    return {14'd0, if0.vec_out, if0.busy, if0.done, if0.pass,
            if0.mismatch_count, if0.first_fail_vld, if0.first_fail_vec};
  endfunction

  // {vec,busy,done,pass,count,ffv,ffvec}
  function automatic logic [31:0] pack(input logic [3:0] v, input logic b, input logic d,
                                       input logic p, input logic [4:0] c, input logic f,
                                       input logic [3:0] fv);
    return {14'd0, v, b, d, p, c, f, fv};
  endfunction

  task automatic run_sweep(input row_t rw, input bit extra);
    inv1   = rw.inv1;
    invall = rw.invall;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    chk("cleared_at_start", status0(), pack(4'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 4'd0));
    for (int k = 0; k < 64; k++) begin
      start = (k == rw.restart_k);
      chk("vec_seq", {if0.busy, if0.done, if0.vec_out}, {1'b1, 1'b0, 4'(k / 4)});
      if (extra && k == 15) chk("dwell1_not_done", if3.done, 1'b0);
      if (extra && k == 16)
        chk("dwell1_done", {if3.done, if3.pass, if3.mismatch_count}, {1'b1, 1'b1, 5'd0});
      tick();
    end
    start = 1'b0;
    chk("final", status0(), pack(4'd15, 1'b0, 1'b1, rw.pass, rw.cnt, rw.ffv, rw.ffvec));
    if (extra) begin
      chk("golden_flip", {if1.pass, if1.mismatch_count, if1.first_fail_vld, if1.first_fail_vec},
          {1'b0, 5'd2, 1'b1, 4'd3});
      chk("golden_off", {if2.done, if2.pass, if2.mismatch_count}, {1'b1, 1'b1, 5'd0});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail + 1);
    $fatal(1);
  end

  initial begin
    rows[0] = '{16'h0000, 16'h0000, -1, 5'd0,  1'b0, 4'd0,  1'b1};
    rows[1] = '{16'h1020, 16'h0000, -1, 5'd2,  1'b1, 4'd5,  1'b0};
    rows[2] = '{16'h0001, 16'h0000, -1, 5'd1,  1'b1, 4'd0,  1'b0};
    rows[3] = '{16'h8000, 16'h0000, 28, 5'd1,  1'b1, 4'd15, 1'b0};
    rows[4] = '{16'hFFFF, 16'h0000, -1, 5'd16, 1'b1, 4'd0,  1'b0};
    rows[5] = '{16'h0000, 16'h0090, -1, 5'd2,  1'b1, 4'd4,  1'b0};
    rows[6] = '{16'h0100, 16'h0100, -1, 5'd1,  1'b1, 4'd8,  1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; inv1 = '0; invall = '0;
    tick(); tick();
    chk("reset", status0(), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", status0(), 32'd0);

    for (int r = 0; r < 7; r++) begin
      run_sweep(rows[r], r == 0);
    end

    // Abort at vec 9 on its sampling cycle; vec 2 failure is kept, vec 9 discarded
    inv1 = '0; invall = 16'h0204;
    start = 1'b1; tick(); start = 1'b0;
    repeat (39) tick();
    chk("pre_abort_vec", if0.vec_out, 4'd9);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abort", status0(), pack(4'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd2));
    repeat (3) tick();
    chk("abort_hold", status0(), pack(4'd0, 1'b0, 1'b0, 1'b0, 5'd1, 1'b1, 4'd2));
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", {if0.busy, if0.done, if0.mismatch_count}, {1'b0, 1'b0, 5'd1});
    run_sweep(rows[0], 1'b0);
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    chk("abort_start_done", {if0.busy, if0.done, if0.vec_out}, {1'b0, 1'b0, 4'd0});
    tick();
    chk("abort_start_stay", {if0.busy, if0.done, if0.vec_out}, {1'b0, 1'b0, 4'd0});

    // Asynchronous reset at vec 6, dwell 2
    inv1 = '0; invall = 16'h0002;
    start = 1'b1; tick(); start = 1'b0;
    repeat (26) tick();
    chk("pre_reset", {if0.vec_out, if0.mismatch_count}, {4'd6, 5'd1});
    rst_n = 1'b0;
    #1;
    chk("async_reset", status0(), 32'd0);
    tick();
    rst_n = 1'b1;
    invall = '0;
    tick();
    run_sweep(rows[0], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
